ascii_dec_a_bin: RTL and testbench
==================================

// Module: ascii_dec_a_bin
// PURPOSE
//  Converts a stream of ASCII decimal characters (one byte per valid cycle, e.g. from a UART
//  receiver or keypad) into an unsigned binary number. This is the inverse of the binary->ASCII
//  BCD digit path that feeds the display/serial output.
//  Digits accumulate MSD first. A terminator (CR/LF) publishes the value with a 1-cycle pulse.
//  Malformed or out-of-range input is reported through a 1-cycle error pulse instead.
// PARAMETERS
//  WIDTH       8  width of the binary result; maximum value is 2^WIDTH-1
//  MAX_DIGITS  4  maximum digits per number, leading zeros included (matches MILL..UNID)
// PORTS
//  clk          in   1      system clock; everything happens on posedge clk
//  rst          in   1      synchronous reset, active-high
//  dato         in   8      ASCII character; sampled only when dato_valido=1
//  dato_valido  in   1      character strobe; one character per cycle, no backpressure
//  numero       out  WIDTH  last successfully converted value; holds until the next success
//  listo        out  1      1-cycle pulse: numero was just updated
//  error        out  1      1-cycle pulse: the terminated number was rejected
//  n_digitos    out  3      digits accumulated in the current number (debug/display)
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - numero=0, listo=0, error=0, n_digitos=0.
//    - Accumulator=0, state=IDLE.
//    - rst overrides a simultaneous dato_valido. Reset mid-number discards the partial value.
//  - Character classes, applied only when dato_valido=1:
//    - DIG: 0x30..0x39.
//    - TERM: 0x0D or 0x0A.
//    - OTRO: everything else.
//    - When dato_valido=0, state and accumulator hold.
//  - FSM states: IDLE (no digits yet), ACUM (digits collected), ERR (discard until TERM).
//    - IDLE: DIG -> acc=d, n=1, go to ACUM. TERM -> ignored; a CR LF pair yields one result.
//      OTRO -> go to ERR.
//    - ACUM: DIG -> acc=acc*10+d, n=n+1; stay in ACUM unless an error condition applies, then ERR.
//      TERM -> numero<=acc, listo=1 in the next cycle, go to IDLE. OTRO -> go to ERR.
//    - ERR: DIG/OTRO -> ignored. TERM -> error=1 in the next cycle, go to IDLE;
//      numero is unchanged.
//  - Arithmetic:
//    - d = dato-8'd48.
//    - acc*10 is formed as (acc<<3)+(acc<<1) in WIDTH+4 bits. No multiplier is used.
//    - The result is never truncated.
//  - Error conditions in ACUM, both move the FSM to ERR:
//    - Overflow: the new accumulator value exceeds 2^WIDTH-1.
//    - Too many digits: a digit arrives while n==MAX_DIGITS.
//  - Latency:
//    - The TERM sampled at edge N gives listo/error high for exactly the cycle after edge N.
//    - numero is valid in that same cycle.
//    - Back-to-back numbers are accepted with zero idle cycles.
//  - Pulses: listo and error are never high together, and each is high for exactly one cycle.
//  - n_digitos: 0 in IDLE, saturates at MAX_DIGITS, returns to 0 after TERM.
// CONFIGURATION
//  SEPARADOR_ESPACIO_EN
//    - Defined: 0x20 (space) is also a TERM, so "12 34\r" gives two results, 12 then 34.
//    - Not defined: 0x20 is OTRO, so the same input gives a single error pulse.
// TESTING
//  - "123\r" -> numero=8'd123, listo pulses once on the cycle after CR; error stays 0.
//  - "255\r\n" -> numero=255, exactly one listo; the LF produces no pulse.
//  - "256\r" after the previous test -> error pulses once; numero remains 255; listo stays 0.
//  - "1a5\r" -> error pulses once. Then "42\n" -> numero=42 with listo, confirming ERR recovery.
//  - "00042\r" with MAX_DIGITS=4 -> error, because of 5 digits.
//    "0042\r" -> numero=42. Characters sent on back-to-back cycles.
//  - "12", assert rst for 1 cycle, then "3\r" -> numero=3.
//    Separately: with SEPARADOR_ESPACIO_EN, "7 8\r" gives two listo pulses, 7 then 8.

Source files
------------

// File: rtl/ascii_dec_a_bin.sv
// rtl/ascii_dec_a_bin.sv - ASCII decimal character stream to unsigned binary converter
//
// Purpose:
//    Accumulates ASCII decimal digits (most significant digit first) into a binary
//    value. A terminator (CR or LF) publishes the value with a one-cycle listo pulse.
//    A malformed or out-of-range number produces a one-cycle error pulse instead.
//
// Optional feature macro:
//    SEPARADOR_ESPACIO_EN - when defined, a space (0x20) also acts as a terminator.
//
// Ports:
//    clk          in   1      system clock, rising edge
//    rst          in   1      synchronous reset, active-high
//    dato         in   8      ASCII character, sampled when dato_valido=1
//    dato_valido  in   1      character strobe, one character per cycle
//    numero       out  WIDTH  last successfully converted value
//    listo        out  1      one-cycle pulse: numero was just updated
//    error        out  1      one-cycle pulse: terminated number was rejected
//    n_digitos    out  3      digits accumulated in the current number

module ascii_dec_a_bin #(
   parameter int WIDTH      = 8,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       dato,
   input  logic             dato_valido,
   output logic [WIDTH-1:0] numero,
   output logic             listo,
   output logic             error,
   output logic [2:0]       n_digitos
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACUM = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [2:0] MAX_N = 3'(MAX_DIGITS);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] numero_next;
   logic [2:0]       n;
   logic [2:0]       n_next;
   logic             listo_next;
   logic             error_next;

   logic             es_dig;
   logic             es_term;
   logic [3:0]       d;
   logic [WIDTH+3:0] acc_x10;
   logic [WIDTH+3:0] acc_new;
   logic             overflow;

   assign es_dig = (dato >= 8'h30) && (dato <= 8'h39);

`ifdef SEPARADOR_ESPACIO_EN
   assign es_term = (dato == 8'h0D) || (dato == 8'h0A) || (dato == 8'h20);
`else
   assign es_term = (dato == 8'h0D) || (dato == 8'h0A);
`endif

   // For '0'..'9' the low nibble equals dato - 48, so no subtractor is needed.
   assign d = dato[3:0];

   // acc*10 built from two shifts; the 4 extra bits hold any overflow so the
   // range check sees the untruncated result.
   assign acc_x10  = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1);
   assign acc_new  = acc_x10 + {{WIDTH{1'b0}}, d};
   assign overflow = |acc_new[WIDTH+3:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         n      <= 3'd0;
         numero <= '0;
         listo  <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_next;
         acc    <= acc_next;
         n      <= n_next;
         numero <= numero_next;
         listo  <= listo_next;
         error  <= error_next;
      end
   end

   // The accumulator is kept at zero whenever the FSM is outside ACUM, so the
   // first digit in IDLE can reuse the same acc*10+d datapath.
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      n_next      = n;
      numero_next = numero;
      listo_next  = 1'b0;
      error_next  = 1'b0;

      case (state)
         IDLE: begin
            if (dato_valido) begin
               if (es_dig) begin
                  acc_next   = acc_new[WIDTH-1:0];
                  n_next     = 3'd1;
                  state_next = overflow ? ERR : ACUM;
               end else if (!es_term) begin
                  state_next = ERR;
               end
            end
         end

         ACUM: begin
            if (dato_valido) begin
               if (es_dig) begin
                  if (n == MAX_N) begin
                     // n stays at MAX_N: n_digitos saturates
                     acc_next   = '0;
                     state_next = ERR;
                  end else if (overflow) begin
                     acc_next   = '0;
                     n_next     = n + 3'd1;
                     state_next = ERR;
                  end else begin
                     acc_next = acc_new[WIDTH-1:0];
                     n_next   = n + 3'd1;
                  end
               end else if (es_term) begin
                  numero_next = acc;
                  listo_next  = 1'b1;
                  acc_next    = '0;
                  n_next      = 3'd0;
                  state_next  = IDLE;
               end else begin
                  acc_next   = '0;
                  state_next = ERR;
               end
            end
         end

         ERR: begin
            if (dato_valido && es_term) begin
               error_next = 1'b1;
               acc_next   = '0;
               n_next     = 3'd0;
               state_next = IDLE;
            end
         end

         default: begin
            acc_next   = '0;
            n_next     = 3'd0;
            state_next = IDLE;
         end
      endcase
   end

   assign n_digitos = n;

endmodule

// File: tb/tb_ascii_dec_a_bin.sv
// tb/tb_ascii_dec_a_bin.sv - directed self-checking bench for ascii_dec_a_bin

module tb_ascii_dec_a_bin;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dato = 8'h00;
   logic       dato_valido = 1'b0;
   logic [7:0] numero;
   logic       listo;
   logic       error;
   logic [2:0] n_digitos;

   int passes = 0;
   int total  = 0;
   int listo_cnt = 0;
   int err_cnt   = 0;
   int both_cnt  = 0;
   logic [7:0] last_num = 8'h00;

   ascii_dec_a_bin #(.WIDTH(8), .MAX_DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .dato        (dato),
      .dato_valido (dato_valido),
      .numero      (numero),
      .listo       (listo),
      .error       (error),
      .n_digitos   (n_digitos)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (listo) begin
         listo_cnt = listo_cnt + 1;
         last_num  = numero;
      end
      if (error) err_cnt = err_cnt + 1;
      if (listo && error) both_cnt = both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] ch);
      @(negedge clk);
      dato        = ch;
      dato_valido = 1'b1;
   endtask

   task automatic gap(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         dato_valido = 1'b0;
      end
      #1;
   endtask

   task automatic clr;
      listo_cnt = 0;
      err_cnt   = 0;
   endtask

   initial begin
      // reset overrides a simultaneous digit
      dato = 8'h35;
      dato_valido = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_numero", numero, 0);
      chk("rst_listo", listo, 0);
      chk("rst_error", error, 0);
      chk("rst_n", n_digitos, 0);
      rst = 1'b0;
      dato_valido = 1'b0;
      gap(2);
      chk("rst_no_digit", n_digitos, 0);
      clr();

      // "123\r": exact one-cycle latency
      send("1"); send("2"); send("3");
      gap(1);
      chk("n_after_123", n_digitos, 3);
      send(8'h0D);
      @(negedge clk);
      dato_valido = 1'b0;
      chk("123_listo", listo, 1);
      chk("123_error", error, 0);
      chk("123_numero", numero, 123);
      @(negedge clk);
      chk("123_listo_drop", listo, 0);
      chk("123_n_zero", n_digitos, 0);
      gap(1);
      clr();

      // "255\r\n": one result only
      send("2"); send("5"); send("5"); send(8'h0D); send(8'h0A);
      gap(3);
      chk("255_listo_cnt", listo_cnt, 1);
      chk("255_err_cnt", err_cnt, 0);
      chk("255_numero", numero, 255);
      clr();

      // "256\r": overflow
      send("2"); send("5"); send("6"); send(8'h0D);
      @(negedge clk);
      dato_valido = 1'b0;
      chk("256_error", error, 1);
      chk("256_listo", listo, 0);
      chk("256_numero", numero, 255);
      @(negedge clk);
      chk("256_error_drop", error, 0);
      gap(1);
      clr();

      // "1a5\r" then "42\n"
      send("1"); send("a"); send("5"); send(8'h0D);
      gap(2);
      chk("1a5_err_cnt", err_cnt, 1);
      chk("1a5_listo_cnt", listo_cnt, 0);
      clr();
      send("4"); send("2"); send(8'h0A);
      gap(2);
      chk("42_listo_cnt", listo_cnt, 1);
      chk("42_last", last_num, 42);
      chk("42_err_cnt", err_cnt, 0);
      clr();

      // "00042\r": too many digits; n saturates
      send("0"); send("0"); send("0"); send("0"); send("4");
      gap(1);
      chk("n_saturated", n_digitos, 4);
      send(8'h0D);
      gap(2);
      chk("00042_err_cnt", err_cnt, 1);
      chk("00042_listo_cnt", listo_cnt, 0);
      clr();
      send("0"); send("0"); send("4"); send("2"); send(8'h0D);
      gap(2);
      chk("0042_listo_cnt", listo_cnt, 1);
      chk("0042_numero", numero, 42);
      chk("0042_err_cnt", err_cnt, 0);
      clr();

      // dato_valido=0 holds state even with junk on dato
      send("1");
      @(negedge clk);
      dato = 8'h41;
      dato_valido = 1'b0;
      @(negedge clk);
      dato = 8'h0D;
      send("5"); send(8'h0D);
      gap(2);
      chk("hold_listo_cnt", listo_cnt, 1);
      chk("hold_numero", numero, 15);
      clr();

      // lone terminators in IDLE are ignored
      send(8'h0D); send(8'h0A);
      gap(2);
      chk("lone_term_listo", listo_cnt, 0);
      chk("lone_term_err", err_cnt, 0);
      clr();

      // back-to-back numbers with zero idle cycles
      send("9"); send(8'h0D); send("7"); send("0"); send(8'h0D);
      gap(2);
      chk("b2b_listo_cnt", listo_cnt, 2);
      chk("b2b_numero", numero, 70);
      clr();

      // reset mid-number discards the partial value
      send("1"); send("2");
      gap(1);
      chk("partial_n", n_digitos, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_numero", numero, 0);
      chk("midrst_n", n_digitos, 0);
      send("3"); send(8'h0D);
      gap(2);
      chk("after_rst_numero", numero, 3);
      chk("after_rst_listo_cnt", listo_cnt, 1);
      clr();

      // space handling depends on the build option
      send("1"); send("2"); send(8'h20); send("3"); send("4"); send(8'h0D);
      gap(2);
`ifdef SEPARADOR_ESPACIO_EN
      chk("space_listo_cnt", listo_cnt, 2);
      chk("space_last", last_num, 34);
      chk("space_err_cnt", err_cnt, 0);
`else
      chk("space_err_cnt", err_cnt, 1);
      chk("space_listo_cnt", listo_cnt, 0);
      chk("space_numero", numero, 3);
`endif
      clr();

      chk("never_both", both_cnt, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
